// File: rtl/bram_access_arbiter.sv
// Shares one simple-dual-port BRAM between NUM_REQ requesters. Read and write ports have independent round-robin arbiters.
// Define ARB_FIXED_PRIO_EN to get fixed lowest-index-wins priority on both ports instead.
module bram_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BRAM_WIDTH = 32,
  parameter int BRAM_DEPTH = 256,
  localparam int AW        = $clog2(BRAM_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*AW-1:0]         wr_addr,
  input  logic [NUM_REQ*BRAM_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*AW-1:0]         rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [BRAM_WIDTH-1:0]         rd_data,
  output logic                          bram_we,
  output logic [AW-1:0]                 bram_addrin,
  output logic [BRAM_WIDTH-1:0]         bram_din,
  output logic                          bram_re,
  output logic [AW-1:0]                 bram_addrout,
  input  logic [BRAM_WIDTH-1:0]         bram_dout
);

  localparam int PW = $clog2(NUM_REQ);

  // First asserting requester found when searching upward from ptr, wrapping at NUM_REQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [PW-1:0]      ptr);
    logic [PW:0]   pos;
    logic [PW-1:0] sel;
    logic          hit;
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(NUM_REQ)) pos = pos - (PW+1)'(NUM_REQ);
      if (!hit && req[pos[PW-1:0]]) begin
        hit = 1'b1;
        sel = pos[PW-1:0];
      end
    end
    return sel;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] sel);
    logic [PW:0] nxt;
    nxt = {1'b0, sel} + (PW+1)'(1);
    return (nxt == (PW+1)'(NUM_REQ)) ? '0 : nxt[PW-1:0];
  endfunction

  logic [PW-1:0]         w_wr_ptr;
  logic [PW-1:0]         w_rd_ptr;
  logic [PW-1:0]         w_wr_sel;
  logic [PW-1:0]         w_rd_sel;
  logic [NUM_REQ-1:0]    w_wr_gnt;
  logic [NUM_REQ-1:0]    w_rd_gnt;
  logic                  w_wr_any;
  logic                  w_rd_any;
  logic [AW-1:0]         w_wr_addr_sel;
  logic [BRAM_WIDTH-1:0] w_wr_data_sel;
  logic [AW-1:0]         w_rd_addr_sel;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;

  assign w_wr_sel = rr_pick(wr_req, w_wr_ptr);
  assign w_rd_sel = rr_pick(rd_req, w_rd_ptr);

  // Grants are suppressed during reset so nothing is accepted on the release edge.
  assign w_wr_gnt = (rst_n && |wr_req) ? (NUM_REQ'(1) << w_wr_sel) : '0;
  assign w_rd_gnt = (rst_n && |rd_req) ? (NUM_REQ'(1) << w_rd_sel) : '0;
  assign w_wr_any = |w_wr_gnt;
  assign w_rd_any = |w_rd_gnt;

`ifdef ARB_FIXED_PRIO_EN
  assign w_wr_ptr = '0;
  assign w_rd_ptr = '0;
`else
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_any) r_wr_ptr <= ptr_after(w_wr_sel);
      if (w_rd_any) r_rd_ptr <= ptr_after(w_rd_sel);
    end
  end

  assign w_wr_ptr = r_wr_ptr;
  assign w_rd_ptr = r_rd_ptr;
`endif

  // One-hot grants make an OR of masked lanes a plain mux.
  always_comb begin
    // NOTE: defaults before the loop keep this block free of inferred latches.
    w_wr_addr_sel = '0;
    w_wr_data_sel = '0;
    w_rd_addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_wr_gnt[i]) begin
        w_wr_addr_sel |= wr_addr[i*AW +: AW];
        w_wr_data_sel |= wr_data[i*BRAM_WIDTH +: BRAM_WIDTH];
      end
      if (w_rd_gnt[i]) w_rd_addr_sel |= rd_addr[i*AW +: AW];
    end
  end

  // Only a non-power-of-2 depth can see addresses past the last word.
  generate
    if (BRAM_DEPTH == (1 << AW)) begin : g_pow2_depth
      assign w_wr_in_range = 1'b1;
      assign w_rd_in_range = 1'b1;
    end else begin : g_npow2_depth
      assign w_wr_in_range = (int'(w_wr_addr_sel) < BRAM_DEPTH);
      assign w_rd_in_range = (int'(w_rd_addr_sel) < BRAM_DEPTH);
    end
  endgenerate

  logic                  r_bram_we;
  logic [AW-1:0]         r_bram_addrin;
  logic [BRAM_WIDTH-1:0] r_bram_din;
  logic                  r_bram_re;
  logic [AW-1:0]         r_bram_addrout;
  logic [NUM_REQ-1:0]    r_rd_pipe;
  logic [NUM_REQ-1:0]    r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bram_we      <= 1'b0;
      r_bram_addrin  <= '0;
      r_bram_din     <= '0;
      r_bram_re      <= 1'b0;
      r_bram_addrout <= '0;
      r_rd_pipe      <= '0;
      r_rd_valid     <= '0;
    end else begin
      r_bram_we <= w_wr_any && w_wr_in_range;
      if (w_wr_any) begin
        r_bram_addrin <= w_wr_addr_sel;
        r_bram_din    <= w_wr_data_sel;
      end
      r_bram_re <= w_rd_any && w_rd_in_range;
      if (w_rd_any && w_rd_in_range) r_bram_addrout <= w_rd_addr_sel;
      // Valid tracks the grant even for suppressed out-of-range reads.
      r_rd_pipe  <= w_rd_gnt;
      r_rd_valid <= r_rd_pipe;
    end
  end

  assign wr_gnt       = w_wr_gnt;
  assign rd_gnt       = w_rd_gnt;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = bram_dout;
  assign bram_we      = r_bram_we;
  assign bram_addrin  = r_bram_addrin;
  assign bram_din     = r_bram_din;
  assign bram_re      = r_bram_re;
  assign bram_addrout = r_bram_addrout;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Scoreboard bench for bram_access_arbiter: the driver pushes expected BRAM writes and read returns,
// a negedge monitor pops and compares them against a behavioural write-first BRAM.
module tb_bram_access_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 256;
  localparam int AW = $clog2(D);

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       wr_req;
  logic [N*AW-1:0]    wr_addr;
  logic [N*W-1:0]     wr_data;
  logic [N-1:0]       wr_gnt;
  logic [N-1:0]       rd_req;
  logic [N*AW-1:0]    rd_addr;
  logic [N-1:0]       rd_gnt;
  logic [N-1:0]       rd_valid;
  logic [W-1:0]       rd_data;
  logic               bram_we;
  logic [AW-1:0]      bram_addrin;
  logic [W-1:0]       bram_din;
  logic               bram_re;
  logic [AW-1:0]      bram_addrout;
  logic [W-1:0]       bram_dout;

  bram_access_arbiter #(.NUM_REQ(N), .BRAM_WIDTH(W), .BRAM_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .bram_we(bram_we), .bram_addrin(bram_addrin), .bram_din(bram_din),
    .bram_re(bram_re), .bram_addrout(bram_addrout), .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural simple-dual-port BRAM, write-first on a same-address collision.
  logic [W-1:0] mem [D];
  initial bram_dout = '0;
  always @(posedge clk) begin
    if (bram_re) bram_dout <= (bram_we && bram_addrin == bram_addrout) ? bram_din : mem[bram_addrout];
    if (bram_we) mem[bram_addrin] <= bram_din;
  end

  typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_exp_t;
  typedef struct { logic [N-1:0] vec; logic [W-1:0] data; } rd_exp_t;

  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  int      rd_cyc[$];
  int      cyc = 0;
  int      n_checks = 0;
  int      n_pass = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every presented BRAM write or read return must match the next expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_we) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_bram_we: got addr %0h din %0h expected no write", bram_addrin, bram_din);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("bram_addrin", 64'(bram_addrin), 64'(e.addr));
          check("bram_din", 64'(bram_din), 64'(e.data));
        end
      end
      if (rd_valid != '0) begin
        rd_cyc.push_back(cyc);
        if (rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rd_valid: got %b expected no pulse", rd_valid);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rd_valid", 64'(rd_valid), 64'(e.vec));
          check("rd_data", 64'(rd_data), 64'(e.data));
        end
      end
    end
  end

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*W +: W]   = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  // One cycle: check grants mid-cycle, record what they must produce, return just after the edge.
  task automatic step(input logic [N-1:0] exp_wg, input logic [N-1:0] exp_rg,
                      input logic [W-1:0] exp_rd, input bit track_rd, input string tag);
    int k;
    @(negedge clk);
    check({tag, " wr_gnt"}, 64'(wr_gnt), 64'(exp_wg));
    check({tag, " rd_gnt"}, 64'(rd_gnt), 64'(exp_rg));
    if (exp_wg != '0) begin
      k = oh_idx(exp_wg);
      wr_q.push_back('{addr: wr_addr[k*AW +: AW], data: wr_data[k*W +: W]});
    end
    if (exp_rg != '0 && track_rd) rd_q.push_back('{vec: exp_rg, data: exp_rd});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_req = '0;
    rd_req = '0;
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, "idle");
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    wr_req = '0;
    rd_req = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] exp_g;
    int           sz;

    rst_n   = 1'b0;
    wr_req  = '1;
    rd_req  = '1;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    #3;
    check("reset wr_gnt", 64'(wr_gnt), 64'(0));
    check("reset rd_gnt", 64'(rd_gnt), 64'(0));
    check("reset bram_we", 64'(bram_we), 64'(0));
    check("reset bram_re", 64'(bram_re), 64'(0));
    check("reset rd_valid", 64'(rd_valid), 64'(0));
    check("reset addrin", 64'(bram_addrin), 64'(0));
    check("reset addrout", 64'(bram_addrout), 64'(0));
    check("reset din", 64'(bram_din), 64'(0));
    wr_req = '0;
    rd_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write, then bram_we must fall again.
    wr_req = 4'b0001;
    set_wr(0, 8'h10, 32'hDEADBEEF);
    step(4'b0001, '0, '0, 1'b0, "single_wr");
    wr_req = '0;
    step('0, '0, '0, 1'b0, "single_wr+1");
    @(negedge clk);
    check("single_wr we_low", 64'(bram_we), 64'(0));
    @(posedge clk);
    #1;

    // Write then read-back by requester 2.
    wr_req = 4'b0001;
    set_wr(0, 8'h20, 32'h12345678);
    step(4'b0001, '0, '0, 1'b0, "wr_0x20");
    wr_req = '0;
    rd_req = 4'b0100;
    set_rd(2, 8'h20);
    step('0, 4'b0100, 32'h12345678, 1'b1, "rd_0x20");
    idle(3);

    // All four writers held for 8 cycles from a fresh reset.
    do_reset();
    for (int i = 0; i < N; i++) set_wr(i, AW'(8'h30 + i), 32'hC0DE0000 + i);
    wr_req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (c % 4);
`endif
      step(exp_g, '0, '0, 1'b0, $sformatf("rr_cycle%0d", c));
    end
    idle(2);

    // Same-cycle write and read of one address returns the new data.
    wr_req = 4'b0010;
    rd_req = 4'b1000;
    set_wr(1, 8'h05, 32'hA5A5A5A5);
    set_rd(3, 8'h05);
    step(4'b0010, 4'b1000, 32'hA5A5A5A5, 1'b1, "wr_rd_collide");
    idle(3);

    // Fill 0..3 via requester 2, then stream reads from requester 0.
    wr_req = 4'b0100;
    for (int a = 0; a < 4; a++) begin
      set_wr(2, AW'(a), 32'h100 + a);
      step(4'b0100, '0, '0, 1'b0, $sformatf("fill%0d", a));
    end
    wr_req = '0;
    rd_req = 4'b0001;
    for (int a = 0; a < 4; a++) begin
      set_rd(0, AW'(a));
      step('0, 4'b0001, 32'h100 + a, 1'b1, $sformatf("stream_rd%0d", a));
    end
    idle(3);
    sz = rd_cyc.size();
    check("stream pulses seen", 64'(sz >= 4), 64'(1));
    if (sz >= 4)
      for (int k = 1; k < 4; k++)
        check($sformatf("stream gap%0d", k), 64'(rd_cyc[sz-4+k] - rd_cyc[sz-5+k]), 64'(1));

    // Read granted, reset pulsed in the following cycle: read must vanish, pointers return to 0.
    rd_req = 4'b0001;
    set_rd(0, 8'h00);
    step('0, 4'b0001, '0, 1'b0, "rd_before_rst");
    rst_n  = 1'b0;
    rd_req = '0;
    #1;
    check("midrst bram_re", 64'(bram_re), 64'(0));
    check("midrst rd_valid", 64'(rd_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      set_wr(i, AW'(8'h40 + i), 32'hBEEF0000 + i);
      set_rd(i, AW'(i));
    end
    wr_req = 4'b1111;
    rd_req = 4'b1111;
    step(4'b0001, 4'b0001, 32'h100, 1'b1, "post_rst_ptr");
    idle(4);

    check("wr_q drained", 64'(wr_q.size()), 64'(0));
    check("rd_q drained", 64'(rd_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
